// File: rtl/johnson_slot_scheduler.sv
// johnson_slot_scheduler: Johnson-counter time-slot arbiter granting one of 2*N requesters at a time
module johnson_slot_scheduler #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int SW       = $clog2(2*N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            dir,
    input  logic            clr,
    input  logic [2*N-1:0]  req,
    input  logic            done,
    output logic [N-1:0]    q,
    output logic [SW-1:0]   slot,
    output logic [2*N-1:0]  grant,
    output logic            busy,
    output logic            timeout,
    output logic            err
);
    localparam int S  = 2*N;
    localparam int HW = $clog2(MAX_HOLD+1);
    typedef enum logic [1:0] {IDLE, RUN, GRANT} state_t;
    state_t        st_q;
    logic [N-1:0]  cnt_q;
    logic [N-1:0]  cnt_d;
    logic [HW-1:0] hold_q;
    logic [S-1:0]  grant_q;
    logic          busy_q;
    logic          timeout_q;
    logic          err_q;
    logic [N-2:0]  edges;
    logic          legal;
    logic          hold_max;
    logic [SW-1:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + SW'(cnt_q[i]);
    end
    // a legal Johnson word has at most one 0/1 boundary between adjacent bits
    assign edges    = cnt_q[N-1:1] ^ cnt_q[N-2:0];
    assign legal    = (edges & (edges - 1'b1)) == '0;
    assign slot     = (!cnt_q[N-1] || &cnt_q) ? pop : SW'(S) - pop;
    assign cnt_d    = dir ? {~cnt_q[0], cnt_q[N-1:1]} : {cnt_q[N-2:0], ~cnt_q[N-1]};
    assign hold_max = hold_q == HW'(MAX_HOLD-1);
    assign q        = cnt_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;
    assign err      = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            if (clr || !legal) begin
                err_q   <= !clr;
                st_q    <= IDLE;
                cnt_q   <= '0;
                hold_q  <= '0;
                grant_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (st_q)
                    IDLE: begin
                        st_q   <= en ? RUN : IDLE;
                        busy_q <= en;
                    end
                    RUN: begin
                        if (!en) begin
                            st_q   <= IDLE;
                            busy_q <= 1'b0;
                        end else if (req[slot]) begin
                            grant_q <= S'(1) << slot;
                            st_q    <= GRANT;
                            hold_q  <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    GRANT: begin
                        if (done || hold_max) begin
                            grant_q   <= '0;
                            cnt_q     <= cnt_d;
                            timeout_q <= !done;
                            st_q      <= en ? RUN : IDLE;
                            busy_q    <= en;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: begin
                        st_q    <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_johnson_slot_scheduler.sv
// tb_johnson_slot_scheduler: table-driven, directed and randomized checks against a slot-level model
module tb_johnson_slot_scheduler;
    localparam int N = 4, S = 8, MH = 16;
    logic       clk = 0, rst_n = 0, en = 0, dir = 0, clr = 0, done = 0;
    logic [7:0] req = '0;
    logic [3:0] q;
    logic [2:0] slot;
    logic [7:0] grant;
    logic       busy, timeout, err;
    int         checks = 0, failures = 0;
    int         n, ms, mst, mh, mg;
    logic       tbad, mto;
    logic [31:0] e;

    johnson_slot_scheduler #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .req(req), .done(done),
        .q(q), .slot(slot), .grant(grant), .busy(busy), .timeout(timeout), .err(err));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic       en, dir, done;
        logic [7:0] req;
        logic [3:0] eq;
        logic [2:0] es;
        logic [7:0] eg;
        logic       eb, et;
    } vec_t;
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; dir = 0; clr = 0; done = 0; req = '0;
        #3;
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] obs();
        return {14'b0, q, slot, grant, busy, timeout, err};
    endfunction

    // Johnson word for slot k: k low ones up to N, then ones draining from the bottom
    function automatic logic [3:0] jq(input int k);
        int v;
        v = (k <= N) ? (1 << k) - 1 : ((1 << N) - 1) ^ ((1 << (k - N)) - 1);
        return v[3:0];
    endfunction

    task automatic model();
        mto = 0;
        if (clr) begin
            ms = 0; mst = 0; mg = -1; mh = 0;
        end else if (mst == 0) begin
            if (en) mst = 1;
        end else if (mst == 1) begin
            if (!en) mst = 0;
            else if (req[ms]) begin mg = ms; mst = 2; mh = 0; end
            else ms = dir ? (ms + S - 1) % S : (ms + 1) % S;
        end else begin
            if (done || mh == MH - 1) begin
                mto = !done; mg = -1;
                ms = dir ? (ms + S - 1) % S : (ms + 1) % S;
                mst = en ? 1 : 0;
            end else mh++;
        end
    endtask

    initial begin
        tbl[0]  = '{1,0,0,8'h00,4'b0000,3'd0,8'h00,1,0};
        tbl[1]  = '{1,0,0,8'h00,4'b0001,3'd1,8'h00,1,0};
        tbl[2]  = '{1,0,0,8'h00,4'b0011,3'd2,8'h00,1,0};
        tbl[3]  = '{1,0,0,8'h00,4'b0111,3'd3,8'h00,1,0};
        tbl[4]  = '{1,0,0,8'h00,4'b1111,3'd4,8'h00,1,0};
        tbl[5]  = '{1,0,0,8'h00,4'b1110,3'd5,8'h00,1,0};
        tbl[6]  = '{1,0,0,8'h00,4'b1100,3'd6,8'h00,1,0};
        tbl[7]  = '{1,0,0,8'h00,4'b1000,3'd7,8'h00,1,0};
        tbl[8]  = '{1,0,0,8'h00,4'b0000,3'd0,8'h00,1,0};
        tbl[9]  = '{1,0,0,8'h08,4'b0001,3'd1,8'h00,1,0};
        tbl[10] = '{1,0,0,8'h08,4'b0011,3'd2,8'h00,1,0};
        tbl[11] = '{1,0,0,8'h08,4'b0111,3'd3,8'h00,1,0};
        tbl[12] = '{1,0,0,8'h08,4'b0111,3'd3,8'h08,1,0};
        tbl[13] = '{1,0,0,8'h08,4'b0111,3'd3,8'h08,1,0};
        tbl[14] = '{1,0,0,8'h08,4'b0111,3'd3,8'h08,1,0};
        tbl[15] = '{1,0,1,8'h08,4'b1111,3'd4,8'h00,1,0};
        tbl[16] = '{1,0,0,8'h00,4'b1110,3'd5,8'h00,1,0};

        do_reset();
        check("reset", obs(), 32'h0);
        for (int i = 0; i < 17; i++) begin
            en = tbl[i].en; dir = tbl[i].dir; done = tbl[i].done; req = tbl[i].req;
            step();
            check($sformatf("tbl[%0d]", i), obs(),
                  {14'b0, tbl[i].eq, tbl[i].es, tbl[i].eg, tbl[i].eb, tbl[i].et, 1'b0});
        end

        // hold timeout on slot 2
        do_reset();
        en = 1; req = 8'h04;
        for (int i = 0; i < 10 && grant == 0; i++) step();
        check("to_grant", {q, grant}, {4'b0011, 8'h04});
        n = 1; tbad = 0;
        for (int i = 0; i < 40 && grant != 0; i++) begin
            step();
            if (grant != 0) begin n++; if (timeout) tbad = 1; end
        end
        check("to_width", n, MH);
        check("to_early", tbad, 0);
        check("to_release", {q, grant, timeout}, {4'b0111, 8'h00, 1'b1});
        req = '0;
        step();
        check("to_pulse", timeout, 0);

        // reverse scan, then en drop during a grant
        do_reset();
        en = 1; dir = 1;
        step();
        step(); check("rev1", q, 4'b1000);
        step(); check("rev2", q, 4'b1100);
        step(); check("rev3", {q, slot}, {4'b1110, 3'd5});
        req = 8'h20;
        step(); check("rev_grant", grant, 8'h20);
        en = 0;
        step(); check("endrop_hold", {grant, busy}, {8'h20, 1'b1});
        done = 1;
        step(); check("endrop_rel", {q, grant, busy, timeout}, {4'b1111, 8'h00, 1'b0, 1'b0});
        done = 0;
        step(); check("endrop_idle", {q, busy}, {4'b1111, 1'b0});

        // illegal counter word recovery
        do_reset();
        en = 1;
        step();
        force dut.cnt_q = 4'b0101;
        step();
        release dut.cnt_q;
        check("illegal_err", {err, busy, grant}, {1'b1, 1'b0, 8'h00});
        step();
        check("illegal_q", q, 4'b0000);

        // clear overrides illegal recovery without err
        do_reset();
        en = 1;
        step();
        force dut.cnt_q = 4'b0101;
        clr = 1;
        step();
        release dut.cnt_q;
        check("clr_err", {err, busy}, 0);
        step();
        check("clr_q", {q, err, grant}, 0);
        clr = 0;

        // asynchronous reset mid-grant
        do_reset();
        en = 1; req = 8'h40;
        for (int i = 0; i < 20 && grant == 0; i++) step();
        check("ar_grant", {q, grant}, {4'b1100, 8'h40});
        #2 rst_n = 0;
        #1 check("ar_clear", obs(), 32'h0);
        @(negedge clk);
        rst_n = 1; req = '0;
        step(); check("ar_run", {q, slot, busy}, {4'b0000, 3'd0, 1'b1});
        step(); check("ar_scan", slot, 3'd1);

        // randomized traffic against the slot-level model
        do_reset();
        ms = 0; mst = 0; mg = -1; mh = 0; mto = 0;
        for (int c = 0; c < 800; c++) begin
            en   = ($urandom % 8) != 0;
            dir  = ($urandom % 6) == 0 ? ~dir : dir;
            req  = 8'($urandom & $urandom & $urandom);
            done = ($urandom % 12) == 0;
            clr  = ($urandom % 80) == 0;
            model();
            step();
            e = {14'b0, jq(ms), ms[2:0], (mg < 0) ? 8'h00 : 8'(1 << mg), mst != 0, mto, 1'b0};
            check($sformatf("rand[%0d]", c), obs(), e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/johnson_slot_scheduler.md
# johnson_slot_scheduler

Time-division arbiter that uses a Johnson counter as its slot generator and shares one downstream resource among 2*N requesters. Each Johnson state is one slot; the requester owning the current slot receives a registered one-hot grant and keeps it until it signals done or a hold timeout expires. Idle slots are skipped at one slot per cycle. Also provides run/stop control, direction control, synchronous clear and recovery from illegal counter states.

## Interface
- N, 4: Johnson counter stages; slot count S = 2*N; N >= 2.
- MAX_HOLD, 16: maximum cycles a grant may stay high; >= 1.
- SW, $clog2(2*N): width of the slot index.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; level-sensitive.
- dir  in  1  0 = forward shift, 1 = reverse shift; sampled on each advance.
- clr  in  1  synchronous clear; highest priority after reset.
- req  in  S  request per slot; req[k] belongs to slot k.
- done  in  1  the granted requester releases the resource.
- q  out  N  Johnson counter state.
- slot  out  SW  slot index decoded from q.
- grant  out  S  one-hot or zero, registered.
- busy  out  1  high when state != IDLE.
- timeout  out  1  one-cycle pulse on forced release.
- err  out  1  one-cycle pulse when an illegal q is detected.

## Operation
- Forward advance: q <= {q[N-2:0], ~q[N-1]}. Reverse advance: q <= {~q[0], q[N-1:1]}.
- Forward sequence for N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then wraps to 0000. Reverse runs the same sequence backwards.
- Slot decode (combinational from q), with p = popcount(q):
  - if q[N-1]==0 or q is all ones: slot = p;
  - otherwise: slot = 2N - p.
  - Example: 1110 gives slot 5; 1000 gives slot 7.
- Legal q is one of the 2N sequence states. Any other value:
  - err pulses for 1 cycle;
  - the next q is 0000;
  - grant is forced to 0;
  - state becomes IDLE.
- FSM states:
  - IDLE: q holds and grant = 0. en=1 moves to RUN on the next edge.
  - RUN, en=0: move to IDLE; q holds.
  - RUN, en=1, req[slot]=1: grant[slot] <= 1; move to GRANT; q holds; hold counter <= 0.
  - RUN, en=1, req[slot]=0: q advances one step in direction dir.
  - GRANT, done=1: grant <= 0 and q advances. Next state is RUN if en=1, else IDLE.
  - GRANT, done=0 and the hold counter has reached MAX_HOLD-1: same release as done, plus timeout pulses for 1 cycle.
  - GRANT, otherwise: grant holds and the hold counter increments.
- en=0 during GRANT does not cut the grant short. The release happens first, then the FSM goes to IDLE.
- req is sampled only in RUN. Dropping req during GRANT has no effect; only done or timeout releases the grant.
- done and the timeout condition in the same cycle are treated as done: timeout stays 0.
- clr=1: next q = 0000, grant = 0, state = IDLE, hold counter = 0. clr overrides every other input and the illegal-state recovery, and err is not pulsed.
- Reset (rst_n=0): q = 0000, slot = 0, grant = 0, busy = 0, timeout = 0, err = 0, state = IDLE, hold counter = 0.

## Timing
- All outputs are registered except slot, which is decoded combinationally from registered q.
- Grant latency: req[slot] sampled high in RUN at edge t gives grant high after edge t.
- Release latency: done sampled high at edge t gives grant low and q advanced after edge t.
- Minimum grant width is 1 cycle.
- Maximum grant width is MAX_HOLD cycles.
- The FSM spends at least one RUN cycle between consecutive grants, including back-to-back grants to adjacent slots.
- A full scan with no requests takes 2N cycles per revolution.
- A direction change takes effect on the first advance after dir changes; q never skips a state.
- Reset is asynchronous assert. Deassertion is synchronized outside this block.

## Test plan
- Free-run, N=4, en=1, dir=0, req=0: q follows 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; slot counts 0..7 and wraps; grant stays 0; busy=1 from the first cycle after en rises.
- Single grant: req=8'b0000_1000, done rises 3 cycles after grant: grant=8'b0000_1000 while q=0111 and stays high exactly 3 cycles; q then advances to 1111; timeout=0.
- Timeout, MAX_HOLD=16: req[2]=1 with done never asserted: grant[2] is high exactly 16 cycles, timeout pulses in the release cycle, q advances 0011 to 0111.
- Reverse and en drop: dir=1 starting at q=0000 gives 1000, 1100, 1110. Then assert en=0 during a grant, with done 2 cycles later: the grant completes, the FSM goes to IDLE with busy=0, and q holds the advanced value.
- Illegal state: force q=0101 in RUN: err pulses 1 cycle, q becomes 0000, state is IDLE, grant=0. The same forcing with clr=1 gives q=0000 and err=0.
- Reset mid-grant: assert rst_n=0 asynchronously while grant[6]=1: all outputs clear immediately without waiting for a clock edge. After release and en=1, scanning restarts from slot 0.
